// File: rtl/coherence_snoop_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coherence_snoop_responder_pkg
// Description : Shared coherence-bus message codes, MESI codes, snoop FSM
//               state type and broadcast decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package coherence_snoop_responder_pkg;

  // Controller -> cache broadcasts
  localparam logic [2:0] C_NO_REQ      = 3'd0;
  localparam logic [2:0] C_RD_BCAST    = 3'd1;
  localparam logic [2:0] ENABLE_WS     = 3'd2;
  localparam logic [2:0] C_FLUSH_BCAST = 3'd3;
  localparam logic [2:0] C_INVLD_BCAST = 3'd4;
  localparam logic [2:0] C_WS_BCAST    = 3'd5;
  localparam logic [2:0] C_RFO_BCAST   = 3'd6;

  // Cache -> controller replies (C_NO_REQ shared)
  localparam logic [2:0] C_WB          = 3'd1;
  localparam logic [2:0] C_EN_ACCESS   = 3'd2;
  localparam logic [2:0] C_FLUSH       = 3'd3;
  localparam logic [2:0] C_INVLD       = 3'd4;

  // MESI line states
  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_DECIDE  = 3'd2,
    ST_RESPOND = 3'd3,
    ST_UPDATE  = 3'd4,
    ST_HOLD    = 3'd5
  } snoop_state_e;

  // True for the broadcasts that start a snoop; ENABLE_WS and C_NO_REQ do not.
  function automatic logic is_broadcast(input logic [2:0] msg);
    return (msg == C_RD_BCAST)    || (msg == C_FLUSH_BCAST) ||
           (msg == C_INVLD_BCAST) || (msg == C_WS_BCAST)    ||
           (msg == C_RFO_BCAST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/coherence_snoop_responder_next.sv
`default_nettype none
// ============================================================================
// Module      : coherence_snoop_responder_next
// Description : Combinational MESI snoop decision (mesi_snoop_next):
//               {broadcast, hit, current MESI} -> {reply, next MESI,
//               reply carries data, array state write needed}.
// Revision    : 1.0 - initial release
// ============================================================================
module coherence_snoop_responder_next
  import coherence_snoop_responder_pkg::*;
(
  input  logic [2:0] i_msg,
  input  logic       i_hit,
  input  logic [1:0] i_mesi,
  output logic [2:0] o_reply,
  output logic [1:0] o_next_mesi,
  output logic       o_needs_data,
  output logic       o_do_update
);

  // Miss or I-state hit answers C_EN_ACCESS and leaves the line alone.
  always_comb begin
    o_reply      = C_EN_ACCESS;
    o_next_mesi  = i_mesi;
    o_needs_data = 1'b0;
    o_do_update  = 1'b0;
    if (i_hit && (i_mesi != MESI_I)) begin
      case (i_msg)
        C_RD_BCAST: begin
          if (i_mesi == MESI_M) begin
            o_reply      = C_WB;
            o_next_mesi  = MESI_S;
            o_needs_data = 1'b1;
            o_do_update  = 1'b1;
          end else if (i_mesi == MESI_E) begin
            o_next_mesi  = MESI_S;
            o_do_update  = 1'b1;
          end
        end
        C_FLUSH_BCAST, C_INVLD_BCAST, C_RFO_BCAST: begin
          o_next_mesi = MESI_I;
          o_do_update = 1'b1;
          if (i_mesi == MESI_M) begin
            o_needs_data = 1'b1;
            if (i_msg == C_FLUSH_BCAST)      o_reply = C_FLUSH;
            else if (i_msg == C_INVLD_BCAST) o_reply = C_INVLD;
            else                             o_reply = C_WB;
          end
        end
        C_WS_BCAST: begin
          // A write-snoop hitting M means two writers: answer, touch nothing.
          if (i_mesi != MESI_M) begin
            o_next_mesi = MESI_I;
            o_do_update = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/coherence_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module      : coherence_snoop_responder
// Description : Cache-side coherence snoop responder. Captures a controller
//               broadcast, reads the snooped line, replies (with line data
//               when the line is dirty) and writes back the new MESI state.
//               Optional build macro SNOOP_STATS_EN adds saturating
//               snoop_count / snoop_hit_count / snoop_wb_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module coherence_snoop_responder
  import coherence_snoop_responder_pkg::*;
#(
  parameter  int STATUS_BITS    = 2,
  parameter  int COHERENCE_BITS = 2,
  parameter  int OFFSET_BITS    = 2,
  parameter  int DATA_WIDTH     = 8,
  parameter  int ADDRESS_WIDTH  = 12,
  parameter  int MSG_BITS       = 3,
  parameter  int INDEX_BITS     = 4,
  localparam int BUS_WIDTH      = STATUS_BITS + COHERENCE_BITS + DATA_WIDTH * (2 ** OFFSET_BITS),
  localparam int TAG_BITS       = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [MSG_BITS-1:0]       coherence_msg_in,
  input  logic [ADDRESS_WIDTH-1:0]  coherence_address,
  output logic [MSG_BITS-1:0]       coherence_msg_out,
  output logic [BUS_WIDTH-1:0]      coherence_data_out,
  output logic                      lookup_en,
  output logic [INDEX_BITS-1:0]     lookup_index,
  input  logic [BUS_WIDTH-1:0]      lookup_line_in,
  input  logic [TAG_BITS-1:0]       lookup_tag_in,
  output logic                      update_en,
  output logic [COHERENCE_BITS-1:0] update_coherence,
  output logic [STATUS_BITS-1:0]    update_status,
`ifdef SNOOP_STATS_EN
  output logic [15:0]               snoop_count,
  output logic [15:0]               snoop_hit_count,
  output logic [15:0]               snoop_wb_count,
`endif
  output logic                      snoop_busy
);

  snoop_state_e              r_state;
  snoop_state_e              w_state_next;

  logic [MSG_BITS-1:0]       r_msg;
  logic [INDEX_BITS-1:0]     r_index;
  logic [TAG_BITS-1:0]       r_tag;
  logic [BUS_WIDTH-1:0]      r_line;
  logic [MSG_BITS-1:0]       r_reply;
  logic [1:0]                r_next_mesi;
  logic                      r_needs_data;
  logic                      r_do_update;

  logic [MSG_BITS-1:0]       r_msg_out;
  logic [BUS_WIDTH-1:0]      r_data_out;
  logic                      r_update_en;
  logic [COHERENCE_BITS-1:0] r_update_coherence;
  logic [STATUS_BITS-1:0]    r_update_status;

  logic [MSG_BITS-1:0]       w_msg_out;
  logic [BUS_WIDTH-1:0]      w_data_out;
  logic                      w_update_en;
  logic [COHERENCE_BITS-1:0] w_update_coherence;
  logic [STATUS_BITS-1:0]    w_update_status;

  logic                      w_accept;
  logic                      w_hit;
  logic [1:0]                w_line_mesi;
  logic [MSG_BITS-1:0]       w_reply;
  logic [1:0]                w_next_mesi;
  logic                      w_needs_data;
  logic                      w_do_update;
  logic                      w_unused;

  // Word-offset bits never matter for a line-granular snoop.
  assign w_unused    = &{1'b0, coherence_address[OFFSET_BITS-1:0]};

  assign w_accept    = (r_state == ST_IDLE) && is_broadcast(coherence_msg_in);
  assign w_line_mesi = lookup_line_in[BUS_WIDTH-STATUS_BITS-1 -: COHERENCE_BITS];
  assign w_hit       = lookup_line_in[BUS_WIDTH-1] && (lookup_tag_in == r_tag);

  coherence_snoop_responder_next u_next (
    .i_msg        (r_msg),
    .i_hit        (w_hit),
    .i_mesi       (w_line_mesi),
    .o_reply      (w_reply),
    .o_next_mesi  (w_next_mesi),
    .o_needs_data (w_needs_data),
    .o_do_update  (w_do_update)
  );

  // State register; captures the broadcast on accept and the decision in DECIDE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_msg        <= '0;
      r_index      <= '0;
      r_tag        <= '0;
      r_line       <= '0;
      r_reply      <= C_NO_REQ;
      r_next_mesi  <= MESI_I;
      r_needs_data <= 1'b0;
      r_do_update  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_msg   <= coherence_msg_in;
        r_index <= coherence_address[OFFSET_BITS +: INDEX_BITS];
        r_tag   <= coherence_address[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
      end
      if (r_state == ST_DECIDE) begin
        r_line       <= lookup_line_in;
        r_reply      <= w_reply;
        r_next_mesi  <= w_next_mesi;
        r_needs_data <= w_needs_data;
        r_do_update  <= w_do_update;
      end
    end
  end

  // Next state plus the values the bus outputs take on the following edge.
  always_comb begin
    w_state_next       = r_state;
    w_msg_out          = C_NO_REQ;
    w_data_out         = '0;
    w_update_en        = 1'b0;
    w_update_coherence = '0;
    w_update_status    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        w_state_next = ST_DECIDE;
      end
      ST_DECIDE: begin
        w_state_next = w_needs_data ? ST_RESPOND : ST_UPDATE;
      end
      ST_RESPOND: begin
        w_msg_out  = r_reply;
        w_data_out = r_line;
        if (coherence_msg_in == C_NO_REQ) w_state_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_update_en = r_do_update;
        if (r_do_update) begin
          w_update_coherence = r_next_mesi;
          w_update_status    = (r_next_mesi == MESI_I) ? '0
                               : {1'b1, {(STATUS_BITS-1){1'b0}}};
        end
        w_msg_out    = r_needs_data ? C_NO_REQ : C_EN_ACCESS;
        w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (coherence_msg_in == C_NO_REQ) begin
          w_state_next = ST_IDLE;
        end else begin
          w_msg_out = r_needs_data ? C_NO_REQ : C_EN_ACCESS;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Registered bus outputs; reset clears them so an aborted snoop never writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_msg_out          <= C_NO_REQ;
      r_data_out         <= '0;
      r_update_en        <= 1'b0;
      r_update_coherence <= '0;
      r_update_status    <= '0;
    end else begin
      r_msg_out          <= w_msg_out;
      r_data_out         <= w_data_out;
      r_update_en        <= w_update_en;
      r_update_coherence <= w_update_coherence;
      r_update_status    <= w_update_status;
    end
  end

  assign coherence_msg_out  = r_msg_out;
  assign coherence_data_out = r_data_out;
  assign update_en          = r_update_en;
  assign update_coherence   = r_update_coherence;
  assign update_status      = r_update_status;
  assign lookup_en          = (r_state == ST_LOOKUP);
  assign lookup_index       = r_index;
  assign snoop_busy         = (r_state != ST_IDLE);

`ifdef SNOOP_STATS_EN
  logic [15:0] r_snoop_count;
  logic [15:0] r_snoop_hit_count;
  logic [15:0] r_snoop_wb_count;

  // Saturating activity counters: accepted broadcasts, hits, data replies.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_snoop_count     <= '0;
      r_snoop_hit_count <= '0;
      r_snoop_wb_count  <= '0;
    end else begin
      if (w_accept && (r_snoop_count != 16'hFFFF))
        r_snoop_count <= r_snoop_count + 16'd1;
      if ((r_state == ST_DECIDE) && w_hit && (r_snoop_hit_count != 16'hFFFF))
        r_snoop_hit_count <= r_snoop_hit_count + 16'd1;
      if ((r_state == ST_DECIDE) && w_needs_data && (r_snoop_wb_count != 16'hFFFF))
        r_snoop_wb_count <= r_snoop_wb_count + 16'd1;
    end
  end

  assign snoop_count     = r_snoop_count;
  assign snoop_hit_count = r_snoop_hit_count;
  assign snoop_wb_count  = r_snoop_wb_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coherence_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_coherence_snoop_responder
// Description : Self-checking bench for coherence_snoop_responder with a
//               small tag/state array model and an expected-reply queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coherence_snoop_responder;
  import coherence_snoop_responder_pkg::*;

  logic        clock;
  logic        reset;
  logic [2:0]  coherence_msg_in;
  logic [11:0] coherence_address;
  logic [2:0]  coherence_msg_out;
  logic [35:0] coherence_data_out;
  logic        lookup_en;
  logic [3:0]  lookup_index;
  logic [35:0] lookup_line_in;
  logic [5:0]  lookup_tag_in;
  logic        update_en;
  logic [1:0]  update_coherence;
  logic [1:0]  update_status;
  logic        snoop_busy;
`ifdef SNOOP_STATS_EN
  logic [15:0] snoop_count;
  logic [15:0] snoop_hit_count;
  logic [15:0] snoop_wb_count;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  reply;
    logic [35:0] data;
    int          n_upd;
    logic [1:0]  coh;
    logic [1:0]  st;
  } exp_t;
  exp_t sb[$];

  logic [35:0] mem_line [16];
  logic [5:0]  mem_tag  [16];

  coherence_snoop_responder dut (
    .clock              (clock),
    .reset              (reset),
    .coherence_msg_in   (coherence_msg_in),
    .coherence_address  (coherence_address),
    .coherence_msg_out  (coherence_msg_out),
    .coherence_data_out (coherence_data_out),
    .lookup_en          (lookup_en),
    .lookup_index       (lookup_index),
    .lookup_line_in     (lookup_line_in),
    .lookup_tag_in      (lookup_tag_in),
    .update_en          (update_en),
    .update_coherence   (update_coherence),
    .update_status      (update_status),
`ifdef SNOOP_STATS_EN
    .snoop_count        (snoop_count),
    .snoop_hit_count    (snoop_hit_count),
    .snoop_wb_count     (snoop_wb_count),
`endif
    .snoop_busy         (snoop_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Array model: data valid one cycle after lookup_en, junk otherwise.
  always @(posedge clock) begin
    if (lookup_en) begin
      lookup_line_in <= mem_line[lookup_index];
      lookup_tag_in  <= mem_tag[lookup_index];
    end else begin
      lookup_line_in <= 36'hF_5A5A_5A5A;
      lookup_tag_in  <= 6'h3F;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    coherence_msg_in = C_NO_REQ;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // One full snoop: expected values queued at drive time, popped at reply.
  task automatic snoop(input string name, input logic [2:0] msg, input logic [11:0] addr,
                       input int hold, input logic [2:0] e_reply, input logic [35:0] e_data,
                       input int e_upd, input logic [1:0] e_coh, input logic [1:0] e_st);
    exp_t e;
    exp_t got;
    int upd;
    int guard;
    logic [1:0] uc;
    logic [1:0] us;
    upd = 0; uc = 2'bxx; us = 2'bxx;
    e.reply = e_reply; e.data = e_data; e.n_upd = e_upd; e.coh = e_coh; e.st = e_st;
    @(negedge clock);
    coherence_msg_in  = msg;
    coherence_address = addr;
    sb.push_back(e);
    @(negedge clock);
    checks++;
    if (lookup_en !== 1'b1 || snoop_busy !== 1'b1 || lookup_index !== addr[5:2]) begin
      failures++;
      $display("FAIL %s lookup: en=%b busy=%b idx=%h expected en=1 busy=1 idx=%h",
               name, lookup_en, snoop_busy, lookup_index, addr[5:2]);
    end
    coherence_address = ~addr;
    repeat (2) @(negedge clock);
    checks++;
    if (coherence_msg_out !== C_NO_REQ) begin
      failures++;
      $display("FAIL %s early_reply: msg_out=%0d expected %0d", name, coherence_msg_out, C_NO_REQ);
    end
    @(negedge clock);
    got = sb.pop_front();
    checks++;
    if (coherence_msg_out !== got.reply) begin
      failures++;
      $display("FAIL %s reply: msg_out=%0d expected %0d", name, coherence_msg_out, got.reply);
    end
    if (got.reply != C_EN_ACCESS) begin
      checks++;
      if (coherence_data_out !== got.data) begin
        failures++;
        $display("FAIL %s data: data_out=%h expected %h", name, coherence_data_out, got.data);
      end
    end
    if (update_en === 1'b1) begin upd++; uc = update_coherence; us = update_status; end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      checks++;
      if (coherence_msg_out !== got.reply) begin
        failures++;
        $display("FAIL %s hold%0d: msg_out=%0d expected %0d", name, i, coherence_msg_out, got.reply);
      end
      if (update_en === 1'b1) begin upd++; uc = update_coherence; us = update_status; end
    end
    coherence_msg_in = C_NO_REQ;
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
      if (update_en === 1'b1) begin upd++; uc = update_coherence; us = update_status; end
    end while (snoop_busy === 1'b1 && guard < 20);
    checks++;
    if (snoop_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s release_timeout: busy=%b expected 0", name, snoop_busy);
    end
    checks++;
    if (upd != got.n_upd) begin
      failures++;
      $display("FAIL %s update_pulses: got %0d expected %0d", name, upd, got.n_upd);
    end
    if (got.n_upd == 1) begin
      checks++;
      if (uc !== got.coh || us !== got.st) begin
        failures++;
        $display("FAIL %s update_value: coh=%0d status=%b expected coh=%0d status=%b",
                 name, uc, us, got.coh, got.st);
      end
    end
    checks++;
    if (coherence_msg_out !== C_NO_REQ) begin
      failures++;
      $display("FAIL %s idle_msg: msg_out=%0d expected %0d", name, coherence_msg_out, C_NO_REQ);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    coherence_msg_in = C_NO_REQ;
    repeat (2) @(negedge clock);
    checks++;
    if (coherence_msg_out !== C_NO_REQ || coherence_data_out !== 36'h0 || lookup_en !== 1'b0 ||
        update_en !== 1'b0 || update_coherence !== 2'b00 || update_status !== 2'b00 ||
        snoop_busy !== 1'b0 || lookup_index !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: msg=%0d data=%h len=%b upd=%b coh=%0d st=%b busy=%b idx=%h expected all 0",
               coherence_msg_out, coherence_data_out, lookup_en, update_en,
               update_coherence, update_status, snoop_busy, lookup_index);
    end
    reset = 1'b0;
  endtask

  task automatic test_rd_m_hit();
    mem_line[9] = {2'b11, MESI_M, 32'hCAFE_F00D}; mem_tag[9] = 6'd2;
    snoop("rd_m_hit", C_RD_BCAST, 12'h0A4, 3, C_WB, {2'b11, MESI_M, 32'hCAFE_F00D}, 1, MESI_S, 2'b10);
  endtask

  task automatic test_rd_e_and_s();
    mem_line[9] = {2'b10, MESI_E, 32'h1111_2222}; mem_tag[9] = 6'd2;
    snoop("rd_e_hit", C_RD_BCAST, 12'h0A4, 0, C_EN_ACCESS, 36'h0, 1, MESI_S, 2'b10);
    mem_line[9] = {2'b10, MESI_S, 32'h1111_2222};
    snoop("rd_s_hit", C_RD_BCAST, 12'h0A4, 0, C_EN_ACCESS, 36'h0, 0, 2'b00, 2'b00);
  endtask

  task automatic test_rfo_e_hit();
    mem_line[9] = {2'b10, MESI_E, 32'h1234_5678}; mem_tag[9] = 6'd2;
    snoop("rfo_e_hit", C_RFO_BCAST, 12'h0A4, 1, C_EN_ACCESS, 36'h0, 1, MESI_I, 2'b00);
  endtask

  task automatic test_invld_miss();
    mem_line[3] = {2'b11, MESI_M, 32'hDEAD_BEEF}; mem_tag[3] = 6'd5;
    snoop("invld_tag_miss", C_INVLD_BCAST, 12'h18C, 1, C_EN_ACCESS, 36'h0, 0, 2'b00, 2'b00);
    mem_line[9] = {2'b01, MESI_M, 32'h0BAD_0BAD}; mem_tag[9] = 6'd2;
    snoop("rd_invalid_line", C_RD_BCAST, 12'h0A4, 0, C_EN_ACCESS, 36'h0, 0, 2'b00, 2'b00);
  endtask

  task automatic test_ws();
    mem_line[9] = {2'b10, MESI_S, 32'h5555_AAAA}; mem_tag[9] = 6'd2;
    snoop("ws_s_hold4", C_WS_BCAST, 12'h0A4, 4, C_EN_ACCESS, 36'h0, 1, MESI_I, 2'b00);
    mem_line[9] = {2'b11, MESI_M, 32'h5555_AAAA};
    snoop("ws_m_error", C_WS_BCAST, 12'h0A4, 0, C_EN_ACCESS, 36'h0, 0, 2'b00, 2'b00);
  endtask

  task automatic test_flush_invld_m();
    mem_line[9] = {2'b11, MESI_M, 32'hA5A5_0F0F}; mem_tag[9] = 6'd2;
    snoop("flush_m_hit", C_FLUSH_BCAST, 12'h0A7, 2, C_FLUSH, {2'b11, MESI_M, 32'hA5A5_0F0F}, 1, MESI_I, 2'b00);
    snoop("invld_m_hit", C_INVLD_BCAST, 12'h0A4, 0, C_INVLD, {2'b11, MESI_M, 32'hA5A5_0F0F}, 1, MESI_I, 2'b00);
    snoop("rfo_m_hit", C_RFO_BCAST, 12'h0A4, 0, C_WB, {2'b11, MESI_M, 32'hA5A5_0F0F}, 1, MESI_I, 2'b00);
  endtask

  task automatic test_ignored();
    @(negedge clock);
    coherence_msg_in = ENABLE_WS;
    coherence_address = 12'h0A4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (snoop_busy !== 1'b0 || lookup_en !== 1'b0) begin
        failures++;
        $display("FAIL enable_ws_ignored: busy=%b lookup_en=%b expected 0 0", snoop_busy, lookup_en);
      end
    end
    coherence_msg_in = C_NO_REQ;
  endtask

  task automatic test_reset_mid_respond();
    int upd;
    upd = 0;
    mem_line[9] = {2'b11, MESI_M, 32'h7777_8888}; mem_tag[9] = 6'd2;
    @(negedge clock);
    coherence_msg_in = C_RD_BCAST;
    coherence_address = 12'h0A4;
    repeat (4) @(negedge clock);
    checks++;
    if (coherence_msg_out !== C_WB) begin
      failures++;
      $display("FAIL reset_mid_respond_pre: msg_out=%0d expected %0d", coherence_msg_out, C_WB);
    end
    reset = 1'b1;
    coherence_msg_in = C_NO_REQ;
    @(negedge clock);
    if (update_en === 1'b1) upd++;
    checks++;
    if (coherence_msg_out !== C_NO_REQ || snoop_busy !== 1'b0 || coherence_data_out !== 36'h0) begin
      failures++;
      $display("FAIL reset_mid_respond_abort: msg=%0d busy=%b data=%h expected 0 0 0",
               coherence_msg_out, snoop_busy, coherence_data_out);
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (update_en === 1'b1) upd++;
    end
    checks++;
    if (upd != 0) begin
      failures++;
      $display("FAIL reset_mid_respond_update: pulses=%0d expected 0", upd);
    end
  endtask

`ifdef SNOOP_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++;
    if (snoop_count !== 16'd0 || snoop_hit_count !== 16'd0 || snoop_wb_count !== 16'd0) begin
      failures++;
      $display("FAIL stats_reset: %0d %0d %0d expected 0 0 0", snoop_count, snoop_hit_count, snoop_wb_count);
    end
    mem_line[3] = {2'b11, MESI_M, 32'hDEAD_BEEF}; mem_tag[3] = 6'd5;
    snoop("stats_miss", C_INVLD_BCAST, 12'h18C, 0, C_EN_ACCESS, 36'h0, 0, 2'b00, 2'b00);
    mem_line[9] = {2'b10, MESI_E, 32'h1234_5678}; mem_tag[9] = 6'd2;
    snoop("stats_e_hit", C_RFO_BCAST, 12'h0A4, 0, C_EN_ACCESS, 36'h0, 1, MESI_I, 2'b00);
    mem_line[9] = {2'b11, MESI_M, 32'hCAFE_F00D};
    snoop("stats_m_hit", C_RD_BCAST, 12'h0A4, 0, C_WB, {2'b11, MESI_M, 32'hCAFE_F00D}, 1, MESI_S, 2'b10);
    checks++;
    if (snoop_count !== 16'd3 || snoop_hit_count !== 16'd2 || snoop_wb_count !== 16'd1) begin
      failures++;
      $display("FAIL stats_counts: %0d %0d %0d expected 3 2 1", snoop_count, snoop_hit_count, snoop_wb_count);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    coherence_msg_in = C_NO_REQ;
    coherence_address = 12'h000;
    for (int i = 0; i < 16; i++) begin
      mem_line[i] = 36'h0;
      mem_tag[i]  = 6'h0;
    end
    test_reset();
    test_rd_m_hit();
    test_rd_e_and_s();
    test_rfo_e_hit();
    test_invld_miss();
    test_ws();
    test_flush_invld_m();
    test_ignored();
    test_reset_mid_respond();
`ifdef SNOOP_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
